// File: rtl/pow_pkg.sv
// pow_pkg: shared FSM states, one-hot {g,e,l} comparator results and byte width for the PoW target check
package pow_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, COMPARE = 2'd1, DONE = 2'd2} state_t;
  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;
endpackage

// File: rtl/mag_cmp8.sv
// mag_cmp8: 8-bit magnitude comparator; a,b in, one-hot g (a>b), e (a==b), l (a<b) out
module mag_cmp8
  import pow_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic              g,
  output logic              e,
  output logic              l
);
  always_comb {g, e, l} = a > b ? GT : a == b ? EQ : LT;
endmodule

// File: rtl/pow_target_check.sv
// pow_target_check: byte-serial MSB-first hash vs target compare; start/hash_in/target_in in, busy/done/gt/eq/lt/meets_target/bytes_cmp registered out
module pow_target_check
  import pow_pkg::*;
#(
  parameter int HASH_BYTES = 32,
  parameter bit INCLUSIVE  = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [8*HASH_BYTES-1:0]         hash_in,
  input  logic [8*HASH_BYTES-1:0]         target_in,
  output logic                            busy,
  output logic                            done,
  output logic                            gt,
  output logic                            eq,
  output logic                            lt,
  output logic                            meets_target,
  output logic [$clog2(HASH_BYTES+1)-1:0] bytes_cmp
);
  localparam int IW = $clog2(HASH_BYTES + 1);
  localparam int W = 8 * HASH_BYTES;
  localparam logic [IW-1:0] LAST = IW'(HASH_BYTES - 1);
  state_t state;
  logic [W-1:0] hs, ts;
  logic [IW-1:0] idx;
  logic g, e, l;
  mag_cmp8 u_cmp (
    .a(hs[W-1 -: BYTE_W]),
    .b(ts[W-1 -: BYTE_W]),
    .g(g),
    .e(e),
    .l(l)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      hs           <= '0;
      ts           <= '0;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      gt           <= 1'b0;
      eq           <= 1'b0;
      lt           <= 1'b0;
      meets_target <= 1'b0;
      bytes_cmp    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          hs    <= hash_in;
          ts    <= target_in;
          idx   <= '0;
          busy  <= 1'b1;
          state <= COMPARE;
        end
        COMPARE: if (!e || idx == LAST) begin
          {gt, eq, lt} <= {g, e, l};
          meets_target <= l | (e & INCLUSIVE);
          bytes_cmp    <= idx + 1'b1;
          done         <= 1'b1;
          state        <= DONE;
        end else begin
          hs  <= hs << BYTE_W;
          ts  <= ts << BYTE_W;
          idx <= idx + 1'b1;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pow_target_check.sv
// tb_pow_target_check: scoreboard bench over 4-byte exclusive/inclusive and 32-byte instances
module tb_pow_target_check;
  import pow_pkg::*;
  typedef struct {
    logic [2:0] v;
    logic       m;
    int         bc;
    int         at;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start_v = '0;
  logic [2:0] busy_v, done_v, gt_v, eq_v, lt_v, mt_v;
  logic [2:0] bc0, bc1;
  logic [5:0] bc2;
  logic [31:0] h4 = '0, t4 = '0;
  logic [255:0] h32 = '0, t32 = '0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  exp_t q[3][$];
  exp_t last[3];
  bit after[3];
  exp_t e;
  logic [2:0] act;
  int bc;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pow_target_check #(.HASH_BYTES(4), .INCLUSIVE(1'b0)) d0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .hash_in(h4), .target_in(t4),
    .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0]),
    .meets_target(mt_v[0]), .bytes_cmp(bc0)
  );
  pow_target_check #(.HASH_BYTES(4), .INCLUSIVE(1'b1)) d1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .hash_in(h4), .target_in(t4),
    .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1]),
    .meets_target(mt_v[1]), .bytes_cmp(bc1)
  );
  pow_target_check d2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .hash_in(h32), .target_in(t32),
    .busy(busy_v[2]), .done(done_v[2]), .gt(gt_v[2]), .eq(eq_v[2]), .lt(lt_v[2]),
    .meets_target(mt_v[2]), .bytes_cmp(bc2)
  );
  function automatic int get_bc(int i);
    return i == 0 ? int'(bc0) : i == 1 ? int'(bc1) : int'(bc2);
  endfunction
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      act = {gt_v[i], eq_v[i], lt_v[i]};
      bc  = get_bc(i);
      if (rst) begin
        q[i].delete();
        last[i]  = '{3'b000, 1'b0, 0, 0};
        after[i] = 1'b0;
        tests++;
        if (busy_v[i] || done_v[i] || act != 3'b000 || mt_v[i] || bc != 0) begin
          fails++;
          $display("FAIL reset_state dut%0d: got busy=%b done=%b gel=%b mt=%b bc=%0d, want all 0",
                   i, busy_v[i], done_v[i], act, mt_v[i], bc);
        end
      end else if (done_v[i]) begin
        tests++;
        if (q[i].size() == 0) begin
          fails++;
          $display("FAIL unexpected_done dut%0d: got done=1 at cyc %0d, want no done", i, cyc);
        end else begin
          e = q[i].pop_front();
          if (act != e.v || mt_v[i] != e.m || bc != e.bc || cyc != e.at || !busy_v[i]) begin
            fails++;
            $display("FAIL verdict dut%0d: got gel=%b mt=%b bc=%0d cyc=%0d busy=%b, want gel=%b mt=%b bc=%0d cyc=%0d busy=1",
                     i, act, mt_v[i], bc, cyc, busy_v[i], e.v, e.m, e.bc, e.at);
          end
          last[i]  = e;
          after[i] = 1'b1;
        end
      end else begin
        if (after[i]) begin
          tests++;
          after[i] = 1'b0;
          if (busy_v[i]) begin
            fails++;
            $display("FAIL busy_after_done dut%0d: got busy=1, want 0", i);
          end
        end
        if (q[i].size() > 0 && cyc > q[i][0].at) begin
          tests++;
          fails++;
          $display("FAIL missed_done dut%0d: got no done by cyc %0d, want done at cyc %0d", i, cyc, q[i][0].at);
          void'(q[i].pop_front());
        end
        tests++;
        if (act != last[i].v || mt_v[i] != last[i].m || bc != last[i].bc) begin
          fails++;
          $display("FAIL hold dut%0d: got gel=%b mt=%b bc=%0d, want gel=%b mt=%b bc=%0d",
                   i, act, mt_v[i], bc, last[i].v, last[i].m, last[i].bc);
        end
      end
    end
  end
  task automatic issue(input int i, input logic [255:0] h, input logic [255:0] t,
                       input logic [2:0] v, input logic m, input int nb, input int lat);
    @(negedge clk);
    if (i == 2) begin
      h32 = h;
      t32 = t;
    end else begin
      h4 = h[31:0];
      t4 = t[31:0];
    end
    start_v[i] = 1'b1;
    q[i].push_back('{v, m, nb, cyc + 1 + lat});
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask
  task automatic wait_idle(input int i);
    for (int n = 0; n < 200 && busy_v[i]; n++) @(negedge clk);
    if (busy_v[i]) begin
      $display("FAIL busy_timeout dut%0d: got busy=1 after 200 cycles, want 0", i);
      $fatal(1);
    end
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    issue(0, 256'h00FF_FFFF, 256'h0100_0000, LT, 1'b1, 1, 1);
    wait_idle(0);
    issue(0, 256'h1234_5679, 256'h1234_5678, GT, 1'b0, 4, 4);
    wait_idle(0);
    issue(0, 256'hDEAD_BEEF, 256'hDEAD_BEEF, EQ, 1'b0, 4, 4);
    wait_idle(0);
    issue(1, 256'hDEAD_BEEF, 256'hDEAD_BEEF, EQ, 1'b1, 4, 4);
    wait_idle(1);
    issue(1, 256'h00FF_FFFF, 256'h0100_0000, LT, 1'b1, 1, 1);
    wait_idle(1);
    issue(1, 256'h1234_BB00, 256'h1234_AA00, GT, 1'b0, 3, 3);
    wait_idle(1);
    issue(0, 256'h1200_0000, 256'h1300_0000, LT, 1'b1, 1, 1);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle(0);
    issue(0, 256'h1234_AA00, 256'h1234_BB00, LT, 1'b1, 3, 3);
    wait_idle(0);
    issue(0, 256'hAB00_0000, 256'h1200_0000, GT, 1'b0, 1, 1);
    wait_idle(0);
    @(negedge clk);
    h4 = 32'h5555_5555;
    t4 = 32'h5555_5555;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    wait_idle(0);
    issue(0, 256'h00FF_FFFF, 256'h0100_0000, LT, 1'b1, 1, 1);
    wait_idle(0);
    issue(2, 256'h0, 256'h1, LT, 1'b1, 32, 32);
    wait_idle(2);
    issue(2, {8'h80, 248'h0}, 256'h0, GT, 1'b0, 1, 1);
    wait_idle(2);
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
